// File: rtl/playback_pkg.sv
// rtl/playback_pkg.sv - shared state encoding and width helpers for the playback controller
package playback_pkg;

    typedef enum logic [2:0] {HALTED, PLAY, PAUSE, DONE} pb_state_t;

    function automatic int pb_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Field widths never collapse to zero bits, so a single track still has a 1-bit index.
    function automatic int pb_width(input int n);
        return (pb_clog2(n) < 1) ? 1 : pb_clog2(n);
    endfunction

endpackage

// File: rtl/track_cursor.sv
// rtl/track_cursor.sv - track index / in-track offset cursor with skip and wrap handling
module track_cursor
    import playback_pkg::*;
#(
    parameter int NUM_TRACKS         = 4,
    parameter int TRACK_WORDS        = 65536,
    parameter int PREV_RESTART_WORDS = 16384,
    parameter int TRK_W              = pb_width(NUM_TRACKS),
    parameter int OFS_W              = pb_width(TRACK_WORDS)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   advance,
    input  logic                   restart,
    input  logic                   next,
    input  logic                   prev,
    input  logic                   wrap,
    output logic [TRK_W+OFS_W-1:0] addr,
    output logic [TRK_W-1:0]       track_idx,
    output logic                   at_end,
    output logic                   at_last,
    output logic                   past_restart
);

    logic [OFS_W-1:0] offset;
    logic [TRK_W-1:0] trk_inc;
    logic [TRK_W-1:0] trk_dec;

    assign addr         = {track_idx, offset};
    assign at_end       = (offset == OFS_W'(TRACK_WORDS - 1));
    assign at_last      = (track_idx == TRK_W'(NUM_TRACKS - 1));
    assign past_restart = (32'(offset) >= 32'(PREV_RESTART_WORDS));
    assign trk_inc      = at_last ? '0 : track_idx + 1'b1;
    assign trk_dec      = (track_idx == '0) ? TRK_W'(NUM_TRACKS - 1) : track_idx - 1'b1;

    always_ff @(posedge Clk) begin
        if (Reset || restart) begin
            track_idx <= '0;
            offset    <= '0;
        end else if (next) begin
            track_idx <= trk_inc;
            offset    <= '0;
        end else if (prev) begin
            if (!past_restart)
                track_idx <= trk_dec;
            offset <= '0;
        end else if (advance) begin
            offset <= at_end ? '0 : offset + 1'b1;
            // Last track without wrap keeps its index; the FSM moves to DONE instead.
            if (at_end && (!at_last || wrap))
                track_idx <= trk_inc;
        end
    end

endmodule

// File: rtl/playback_ctrl.sv
// rtl/playback_ctrl.sv - load/play FSM issuing one sample read per codec tick over a multi-track cursor
module playback_ctrl
    import playback_pkg::*;
#(
    parameter int NUM_TRACKS         = 4,
    parameter int TRACK_WORDS        = 65536,
    parameter int AUTO_PLAY          = 1,
    parameter int PREV_RESTART_WORDS = 16384,
    localparam int TRK_W             = pb_width(NUM_TRACKS),
    localparam int ADDR_W            = TRK_W + pb_width(TRACK_WORDS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RAM_INIT_DONE,
    input  logic              play_pause,
    input  logic              next_trk,
    input  logic              prev_trk,
    input  logic              loop_en,
    input  logic              sample_tick,
    output logic              LOAD_MEM,
    output logic              PLAY,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              sample_rd,
    output logic [TRK_W-1:0]  track_idx,
    output logic              done
);

    pb_state_t         state, state_nx;
    logic              adv, restart, nxt, prv, rd_nx;
    logic              at_end, at_last, past_restart;
    logic [ADDR_W-1:0] cur_addr;

    track_cursor #(
        .NUM_TRACKS        (NUM_TRACKS),
        .TRACK_WORDS       (TRACK_WORDS),
        .PREV_RESTART_WORDS(PREV_RESTART_WORDS)
    ) u_cursor (
        .Clk         (Clk),
        .Reset       (Reset),
        .advance     (adv),
        .restart     (restart),
        .next        (nxt),
        .prev        (prv),
        .wrap        (loop_en),
        .addr        (cur_addr),
        .track_idx   (track_idx),
        .at_end      (at_end),
        .at_last     (at_last),
        .past_restart(past_restart)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= HALTED;
            LOAD_MEM    <= 1'b1;
            PLAY        <= 1'b0;
            done        <= 1'b0;
            sample_rd   <= 1'b0;
            sample_addr <= '0;
        end else begin
            state     <= state_nx;
            LOAD_MEM  <= (state_nx == HALTED);
            PLAY      <= (state_nx == playback_pkg::PLAY);
            done      <= (state_nx == DONE);
            sample_rd <= rd_nx;
            if (rd_nx)
                sample_addr <= cur_addr;
        end
    end

    // Buttons are mutually exclusive by priority; any button swallows a coincident tick.
    always_comb begin
        state_nx = state;
        adv      = 1'b0;
        restart  = 1'b0;
        nxt      = 1'b0;
        prv      = 1'b0;
        rd_nx    = 1'b0;
        case (state)
            HALTED: begin
                if (RAM_INIT_DONE)
                    state_nx = (AUTO_PLAY != 0) ? playback_pkg::PLAY : PAUSE;
            end
            default: begin
                if (next_trk) begin
                    nxt = 1'b1;
                    if (state == DONE) state_nx = PAUSE;
                end else if (prev_trk) begin
                    prv = 1'b1;
                    if (state == DONE) state_nx = PAUSE;
                end else if (play_pause) begin
                    if (state == playback_pkg::PLAY) begin
                        state_nx = PAUSE;
                    end else begin
                        state_nx = playback_pkg::PLAY;
                        restart  = (state == DONE);
                    end
                end else if (sample_tick && state == playback_pkg::PLAY) begin
                    adv   = 1'b1;
                    rd_nx = 1'b1;
                    if (at_end && at_last && !loop_en)
                        state_nx = DONE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_playback_ctrl.sv
// tb/tb_playback_ctrl.sv - scoreboard bench for playback_ctrl against a linear-cursor reference model
module tb_playback_ctrl;

    localparam int NT  = 2;
    localparam int TW  = 8;
    localparam int PRW = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       RAM_INIT_DONE = 1'b0;
    logic       play_pause = 1'b0;
    logic       next_trk = 1'b0;
    logic       prev_trk = 1'b0;
    logic       loop_en = 1'b0;
    logic       sample_tick = 1'b0;
    logic       LOAD_MEM, PLAY, sample_rd, done;
    logic [3:0] sample_addr;
    logic [0:0] track_idx;

    always #5 Clk = ~Clk;

    playback_ctrl #(
        .NUM_TRACKS(NT), .TRACK_WORDS(TW), .AUTO_PLAY(1), .PREV_RESTART_WORDS(PRW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .RAM_INIT_DONE(RAM_INIT_DONE),
        .play_pause(play_pause), .next_trk(next_trk), .prev_trk(prev_trk),
        .loop_en(loop_en), .sample_tick(sample_tick), .LOAD_MEM(LOAD_MEM),
        .PLAY(PLAY), .sample_addr(sample_addr), .sample_rd(sample_rd),
        .track_idx(track_idx), .done(done)
    );

    typedef struct { int due; int addr; } strobe_t;
    typedef struct { int due; int load; int play; int dn; int trk; int addr; } status_t;

    strobe_t strobe_q[$];
    status_t status_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Reference model: 0 halted, 1 play, 2 pause, 3 done
    int m_st = 0, m_trk = 0, m_ofs = 0, m_addr = 0;
    bit rid_v = 0, loop_v = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit pp, input bit nx, input bit pv, input bit tk);
        @(posedge Clk);
        #1;
        Reset = rst; RAM_INIT_DONE = rid_v; loop_en = loop_v;
        play_pause = pp; next_trk = nx; prev_trk = pv; sample_tick = tk;
        if (rst) begin
            m_st = 0; m_trk = 0; m_ofs = 0; m_addr = 0;
        end else if (m_st == 0) begin
            if (rid_v) m_st = 1;
        end else if (nx) begin
            m_trk = (m_trk + 1) % NT; m_ofs = 0;
            if (m_st == 3) m_st = 2;
        end else if (pv) begin
            if (m_ofs < PRW) m_trk = (m_trk + NT - 1) % NT;
            m_ofs = 0;
            if (m_st == 3) m_st = 2;
        end else if (pp) begin
            if (m_st == 1) m_st = 2;
            else if (m_st == 2) m_st = 1;
            else begin m_st = 1; m_trk = 0; m_ofs = 0; end
        end else if (tk && m_st == 1) begin
            m_addr = m_trk * TW + m_ofs;
            strobe_q.push_back('{cyc + 1, m_addr});
            m_ofs++;
            if (m_ofs == TW) begin
                m_ofs = 0;
                if (m_trk < NT - 1) m_trk++;
                else if (loop_v) m_trk = 0;
                else m_st = 3;
            end
        end
        status_q.push_back('{cyc + 1, int'(m_st == 0), int'(m_st == 1), int'(m_st == 3), m_trk, m_addr});
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(0, 0, 0, 0, 1);
            idle($urandom_range(0, 2));
        end
    endtask

    always @(negedge Clk) begin
        status_t s;
        strobe_t e;
        while (status_q.size() > 0 && status_q[0].due <= cyc) begin
            s = status_q.pop_front();
            chk("load_mem", int'(LOAD_MEM), s.load);
            chk("play", int'(PLAY), s.play);
            chk("done", int'(done), s.dn);
            chk("track_idx", int'(track_idx), s.trk);
            chk("sample_addr_hold", int'(sample_addr), s.addr);
        end
        if (sample_rd === 1'b1) begin
            checks++;
            if (strobe_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cycle %0d: got strobe addr %0d expected none", cyc, sample_addr);
            end else begin
                e = strobe_q.pop_front();
                chk("strobe_addr", int'(sample_addr), e.addr);
                chk("strobe_latency", cyc, e.due);
            end
        end
        while (strobe_q.size() > 0 && strobe_q[0].due < cyc) begin
            e = strobe_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe cycle %0d: got no strobe expected addr %0d due %0d", cyc, e.addr, e.due);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(20);
        rid_v = 1;
        idle(2);
        // full playlist without loop, then ticks in DONE
        loop_v = 0;
        ticks(16);
        ticks(3);
        step(0, 1, 0, 0, 0);
        // loop across the playlist end
        loop_v = 1;
        ticks(17);
        // prev restart vs skip back
        step(1, 0, 0, 0, 0);
        idle(2);
        ticks(5);
        step(0, 0, 0, 1, 0);
        ticks(2);
        step(0, 0, 0, 1, 0);
        ticks(1);
        // simultaneous events and pause freeze
        step(0, 0, 1, 1, 1);
        step(0, 1, 0, 0, 0);
        ticks(3);
        step(0, 1, 0, 0, 0);
        ticks(2);
        // reset mid-track
        step(1, 0, 0, 0, 0);
        idle(2);
        ticks(11);
        step(1, 0, 0, 0, 0);
        idle(3);
        // randomized traffic
        repeat (3000) begin
            if ($urandom_range(0, 99) == 0) rid_v = ~rid_v;
            if ($urandom_range(0, 49) == 0) loop_v = ~loop_v;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 1) == 1);
        end
        idle(5);
        chk("strobe_queue_drained", strobe_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
